// File: rtl/vend_ctrl.sv
// Vending controller: coin credit, single-item dispense with ack timeout, and refund.
// Define VEND_CHANGE_EN to return overpaid credit after a successful vend.
module vend_ctrl #(
  parameter int unsigned PRICE_HALVES = 3,
  parameter int unsigned STOCK_MAX    = 15,
  parameter int unsigned ACK_TIMEOUT  = 100
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pi_money_one,
  input  logic       pi_money_half,
  input  logic       pi_cancel,
  input  logic       pi_refill,
  input  logic       pi_disp_ack,
  output logic       po_disp_req,
  output logic       po_return_half,
  output logic       po_coin_reject,
  output logic       po_sold_out,
  output logic       po_fault,
  output logic [3:0] po_credit
);

  localparam logic [3:0]  PRICE        = 4'(PRICE_HALVES);
  localparam logic [7:0]  STOCK_FULL   = 8'(STOCK_MAX);
  localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    COLLECT = 4'b0010,
    VEND    = 4'b0100,
    RETURN  = 4'b1000
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  credit_q, credit_d;
  logic [7:0]  stock_q, stock_d;
  logic [15:0] timer_q, timer_d;
  logic        sold_out_q;
  logic        reject_q, reject_d;
  logic        return_q, return_d;
  logic        fault_q, fault_d;

  logic [1:0]  coin_val;
  logic [4:0]  credit_sum;
  logic        coin_any;
  logic        coin_accept;

  // A one-yuan pulse is worth two halves, so the pair of pulses is the coin value.
  assign coin_val    = {pi_money_one, pi_money_half};
  assign coin_any    = pi_money_one | pi_money_half;
  assign credit_sum  = {1'b0, credit_q} + {3'b000, coin_val};
  assign coin_accept = coin_any && !sold_out_q && (credit_sum <= 5'd15) &&
                       ((state_q == IDLE) || (state_q == COLLECT));

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    stock_d  = stock_q;
    timer_d  = timer_q;
    reject_d = coin_any && !coin_accept;
    return_d = 1'b0;
    fault_d  = 1'b0;

    if (coin_accept) begin
      credit_d = credit_sum[3:0];
    end

    case (state_q)
      IDLE: begin
        if (coin_accept) begin
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (pi_cancel) begin
          state_d = RETURN;
        end else if (credit_q >= PRICE) begin
          state_d = VEND;
          timer_d = 16'd0;
        end
      end
      VEND: begin
        if (pi_disp_ack) begin
          stock_d = stock_q - 8'd1;
          timer_d = 16'd0;
`ifdef VEND_CHANGE_EN
          credit_d = credit_q - PRICE;
          state_d  = RETURN;
`else
          credit_d = 4'd0;
          state_d  = IDLE;
`endif
        end else if (timer_q == TIMEOUT_LAST) begin
          // Dispenser never answered: refund everything through RETURN.
          fault_d = 1'b1;
          timer_d = 16'd0;
          state_d = RETURN;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      RETURN: begin
        if (credit_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          credit_d = credit_q - 4'd1;
          return_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Refill overrides any same-cycle vend decrement.
    if (pi_refill) begin
      stock_d = STOCK_FULL;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      credit_q   <= 4'd0;
      stock_q    <= STOCK_FULL;
      timer_q    <= 16'd0;
      sold_out_q <= 1'b0;
      reject_q   <= 1'b0;
      return_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      stock_q    <= stock_d;
      timer_q    <= timer_d;
      sold_out_q <= (stock_d == 8'd0);
      reject_q   <= reject_d;
      return_q   <= return_d;
      fault_q    <= fault_d;
    end
  end

  assign po_disp_req    = (state_q == VEND);
  assign po_return_half = return_q;
  assign po_coin_reject = reject_q;
  assign po_sold_out    = sold_out_q;
  assign po_fault       = fault_q;
  assign po_credit      = credit_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: stimulus pushes expected output events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_vend_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       pi_money_one = 1'b0;
  logic       pi_money_half = 1'b0;
  logic       pi_cancel = 1'b0;
  logic       pi_refill = 1'b0;
  logic       pi_disp_ack = 1'b0;
  logic       po_disp_req;
  logic       po_return_half;
  logic       po_coin_reject;
  logic       po_sold_out;
  logic       po_fault;
  logic [3:0] po_credit;

  vend_ctrl dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .pi_money_one   (pi_money_one),
    .pi_money_half  (pi_money_half),
    .pi_cancel      (pi_cancel),
    .pi_refill      (pi_refill),
    .pi_disp_ack    (pi_disp_ack),
    .po_disp_req    (po_disp_req),
    .po_return_half (po_return_half),
    .po_coin_reject (po_coin_reject),
    .po_sold_out    (po_sold_out),
    .po_fault       (po_fault),
    .po_credit      (po_credit)
  );

  always #5 sys_clk = ~sys_clk;

  typedef enum logic [1:0] {EV_REQ, EV_RET, EV_REJ, EV_FAULT} evKind_t;
  typedef struct packed {
    evKind_t    kind;
    logic [3:0] credit;
  } expEvent_t;

  expEvent_t expQ[$];
  int testsRun = 0;
  int testsFailed = 0;
  logic prevReq = 1'b0;

  task automatic expectEvent(input evKind_t k, input logic [3:0] c);
    expEvent_t e;
    e.kind = k;
    e.credit = c;
    expQ.push_back(e);
  endtask

  task automatic compareEvent(input evKind_t k);
    expEvent_t e;
    testsRun++;
    if (expQ.size() == 0) begin
      testsFailed++;
      $display("[TB] FAIL unexpected event %s: got credit %0d, required no event", k.name(), po_credit);
    end else begin
      e = expQ.pop_front();
      if (e.kind != k || e.credit != po_credit) begin
        testsFailed++;
        $display("[TB] FAIL event order: got %s credit %0d, required %s credit %0d",
                 k.name(), po_credit, e.kind.name(), e.credit);
      end
    end
  endtask

  // Monitor: every output event observed is matched against the scoreboard.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      prevReq <= 1'b0;
    end else begin
      if (po_disp_req && !prevReq) compareEvent(EV_REQ);
      if (po_return_half)          compareEvent(EV_RET);
      if (po_coin_reject)          compareEvent(EV_REJ);
      if (po_fault)                compareEvent(EV_FAULT);
      prevReq <= po_disp_req;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic one, input logic half, input logic cancel,
                               input logic refill, input logic ack);
    pi_money_one  = one;
    pi_money_half = half;
    pi_cancel     = cancel;
    pi_refill     = refill;
    pi_disp_ack   = ack;
    tick(1);
    pi_money_one  = 1'b0;
    pi_money_half = 1'b0;
    pi_cancel     = 1'b0;
    pi_refill     = 1'b0;
    pi_disp_ack   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #12;
    checkOutput("reset credit", 16'(po_credit), 16'd0);
    checkOutput("reset disp_req", 16'(po_disp_req), 16'd0);
    checkOutput("reset sold_out", 16'(po_sold_out), 16'd0);
    checkOutput("reset pulses", 16'({po_return_half, po_coin_reject, po_fault}), 16'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick(1);

    // Exact price: half then one, ack after 5 cycles, no change due.
    expectEvent(EV_REQ, 4'd3);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("credit half+one", 16'(po_credit), 16'd3);
    tick(1);
    checkOutput("disp_req in vend", 16'(po_disp_req), 16'd1);
    tick(4);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("credit after vend", 16'(po_credit), 16'd0);
    checkOutput("disp_req after ack", 16'(po_disp_req), 16'd0);
    tick(2);

    // Overpay: one, one gives credit 4.
    expectEvent(EV_REQ, 4'd4);
`ifdef VEND_CHANGE_EN
    expectEvent(EV_RET, 4'd0);
`endif
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    tick(2);
    applyStimulus(0, 0, 0, 0, 1);
`ifdef VEND_CHANGE_EN
    checkOutput("change credit after ack", 16'(po_credit), 16'd1);
`else
    checkOutput("forfeit credit after ack", 16'(po_credit), 16'd0);
`endif
    tick(2);
    checkOutput("credit after overpay", 16'(po_credit), 16'd0);

    // Both coins at once, then a coin during VEND is rejected.
    expectEvent(EV_REQ, 4'd3);
    expectEvent(EV_REJ, 4'd3);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("credit both coins", 16'(po_credit), 16'd3);
    tick(1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("credit after vend reject", 16'(po_credit), 16'd3);
    applyStimulus(0, 0, 0, 0, 1);
    tick(2);
    checkOutput("credit after vend 3", 16'(po_credit), 16'd0);

    // Cancel with credit 2.
    expectEvent(EV_RET, 4'd1);
    expectEvent(EV_RET, 4'd0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("credit one coin", 16'(po_credit), 16'd2);
    tick(1);
    applyStimulus(0, 0, 1, 0, 0);
    tick(3);
    checkOutput("credit after cancel", 16'(po_credit), 16'd0);

    // Cancel coinciding with a coin: coin counted, everything returned.
    expectEvent(EV_RET, 4'd2);
    expectEvent(EV_RET, 4'd1);
    expectEvent(EV_RET, 4'd0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("credit cancel+coin", 16'(po_credit), 16'd3);
    checkOutput("no vend on cancel", 16'(po_disp_req), 16'd0);
    tick(4);
    checkOutput("credit after cancel+coin", 16'(po_credit), 16'd0);

    // Ack timeout after 100 VEND cycles: fault, full refund.
    expectEvent(EV_REQ, 4'd3);
    expectEvent(EV_FAULT, 4'd3);
    expectEvent(EV_RET, 4'd2);
    expectEvent(EV_RET, 4'd1);
    expectEvent(EV_RET, 4'd0);
    applyStimulus(1, 1, 0, 0, 0);
    tick(1);
    tick(99);
    checkOutput("disp_req before timeout", 16'(po_disp_req), 16'd1);
    tick(1);
    checkOutput("disp_req after timeout", 16'(po_disp_req), 16'd0);
    checkOutput("credit at fault", 16'(po_credit), 16'd3);
    tick(4);
    checkOutput("credit after refund", 16'(po_credit), 16'd0);

    // Stock is now 12 (three vends, fault did not consume); drain to 1.
    for (int i = 0; i < 11; i++) begin
      expectEvent(EV_REQ, 4'd3);
      applyStimulus(1, 1, 0, 0, 0);
      tick(2);
      applyStimulus(0, 0, 0, 0, 1);
      tick(2);
    end
    checkOutput("sold_out at stock 1", 16'(po_sold_out), 16'd0);
    expectEvent(EV_REQ, 4'd3);
    applyStimulus(1, 1, 0, 0, 0);
    tick(2);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("sold_out at stock 0", 16'(po_sold_out), 16'd1);
    tick(2);

    expectEvent(EV_REJ, 4'd0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("credit when sold out", 16'(po_credit), 16'd0);
    expectEvent(EV_REJ, 4'd0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("sold_out after refill", 16'(po_sold_out), 16'd0);
    checkOutput("credit refill+coin", 16'(po_credit), 16'd0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("credit after refill coin", 16'(po_credit), 16'd1);
    expectEvent(EV_RET, 4'd0);
    applyStimulus(0, 0, 1, 0, 0);
    tick(3);
    checkOutput("credit after final cancel", 16'(po_credit), 16'd0);

    // Reset in the middle of RETURN discards remaining credit.
    expectEvent(EV_RET, 4'd1);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    tick(1);
    @(negedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("credit in reset", 16'(po_credit), 16'd0);
    checkOutput("return in reset", 16'(po_return_half), 16'd0);
    tick(2);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick(5);
    checkOutput("credit after reset", 16'(po_credit), 16'd0);
    checkOutput("sold_out after reset", 16'(po_sold_out), 16'd0);
    checkOutput("scoreboard drained", 16'(expQ.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
